// File: rtl/kitchen_order_scheduler.sv
// Two-table order intake with per-item stock, per-table FIFOs and a one-dish kitchen FSM.
// Define KITCHEN_BILL_EN to build the per-table saturating bill accumulators.
module kitchen_order_scheduler #(
    parameter int unsigned QDEPTH   = 4,
    parameter logic [3:0]  INV_INIT = 4'd5,
    parameter logic [7:0]  PREP0    = 8'd2,
    parameter logic [7:0]  PREP1    = 8'd3,
    parameter logic [7:0]  PREP2    = 8'd4,
    parameter logic [7:0]  PREP3    = 8'd5,
    parameter logic [7:0]  PRICE0   = 8'd10,
    parameter logic [7:0]  PRICE1   = 8'd20,
    parameter logic [7:0]  PRICE2   = 8'd30,
    parameter logic [7:0]  PRICE3   = 8'd40
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              table0_order_item,
    input  logic                    table0_order_valid,
    input  logic [1:0]              table1_order_item,
    input  logic                    table1_order_valid,
    input  logic                    restock,
    output logic                    table0_order_reject,
    output logic                    table1_order_reject,
    output logic [$clog2(QDEPTH):0] table0_queue_size,
    output logic [$clog2(QDEPTH):0] table1_queue_size,
    output logic                    item_ready,
    output logic                    ready_table,
    output logic [1:0]              ready_item,
    output logic [7:0]              table0_bill,
    output logic [7:0]              table1_bill,
    output logic                    kitchen_busy,
    output logic [3:0]              stock_empty
);
    localparam int unsigned       PTR_W = $clog2(QDEPTH);
    localparam int unsigned       CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0]  FULL  = CNT_W'(QDEPTH);

    typedef enum logic [1:0] {IDLE, LOAD, COOK, DONE} state_t;

    state_t           state_q, state_d;
    logic             rr_q, rr_d;
    logic             cur_table_q, cur_table_d;
    logic [1:0]       cur_item_q, cur_item_d;
    logic [7:0]       timer_q, timer_d;
    logic [1:0]       mem_q [2][QDEPTH];
    logic [1:0]       mem_d [2][QDEPTH];
    logic [PTR_W-1:0] wr_ptr_q [2];
    logic [PTR_W-1:0] wr_ptr_d [2];
    logic [PTR_W-1:0] rd_ptr_q [2];
    logic [PTR_W-1:0] rd_ptr_d [2];
    logic [CNT_W-1:0] size_q [2];
    logic [CNT_W-1:0] size_d [2];
    logic [3:0]       stock_q [4];
    logic [3:0]       stock_d [4];

    logic [1:0] item_in [2];
    logic       valid_in [2];
    logic       elig [2];
    logic       push [2];
    logic       pop [2];
    logic       sel;
    logic [1:0] head_item;

    function automatic logic [7:0] prep_of(input logic [1:0] item);
        case (item)
            2'd0:    return PREP0;
            2'd1:    return PREP1;
            2'd2:    return PREP2;
            default: return PREP3;
        endcase
    endfunction

    // Pop decision comes first: a pop from a full FIFO frees a slot for a same-cycle push.
    always_comb begin
        item_in[0]  = table0_order_item;
        item_in[1]  = table1_order_item;
        valid_in[0] = table0_order_valid;
        valid_in[1] = table1_order_valid;
        pop[0]      = 1'b0;
        pop[1]      = 1'b0;
        sel         = rr_q;
        if (state_q == IDLE) begin
            if (size_q[rr_q] != '0) begin
                pop[rr_q] = 1'b1;
            end else if (size_q[~rr_q] != '0) begin
                sel        = ~rr_q;
                pop[~rr_q] = 1'b1;
            end
        end
        head_item = mem_q[sel][rd_ptr_q[sel]];

        for (int t = 0; t < 2; t++) begin
            elig[t] = valid_in[t] && !restock && (size_q[t] != FULL || pop[t])
                      && (stock_q[item_in[t]] != 4'd0);
            push[t] = elig[t];
        end
        if (elig[0] && elig[1] && item_in[0] == item_in[1] && stock_q[item_in[0]] == 4'd1)
            push[~rr_q] = 1'b0;
    end

    // NOTE: every variable is given its hold value before any branch so no path infers a latch.
    always_comb begin
        mem_d = mem_q;
        for (int t = 0; t < 2; t++) begin
            wr_ptr_d[t] = wr_ptr_q[t];
            rd_ptr_d[t] = rd_ptr_q[t];
            size_d[t]   = size_q[t];
            if (push[t]) begin
                mem_d[t][wr_ptr_q[t]] = item_in[t];
                wr_ptr_d[t]           = wr_ptr_q[t] + PTR_W'(1);
            end
            if (pop[t])
                rd_ptr_d[t] = rd_ptr_q[t] + PTR_W'(1);
            if (push[t] && !pop[t])
                size_d[t] = size_q[t] + CNT_W'(1);
            else if (pop[t] && !push[t])
                size_d[t] = size_q[t] - CNT_W'(1);
        end
        for (int i = 0; i < 4; i++) begin
            if (restock)
                stock_d[i] = INV_INIT;
            else
                stock_d[i] = stock_q[i] - 4'(push[0] && item_in[0] == 2'(i))
                                        - 4'(push[1] && item_in[1] == 2'(i));
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        cur_table_d = cur_table_q;
        cur_item_d  = cur_item_q;
        timer_d     = timer_q;
        case (state_q)
            IDLE: begin
                if (pop[0] || pop[1]) begin
                    cur_table_d = sel;
                    cur_item_d  = head_item;
                    timer_d     = prep_of(head_item);
                    state_d     = LOAD;
                end
            end
            LOAD: state_d = COOK;
            COOK: begin
                timer_d = timer_q - 8'd1;
                if (timer_q <= 8'd1)
                    state_d = DONE;
            end
            DONE: begin
                rr_d    = ~cur_table_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rr_q        <= 1'b0;
            cur_table_q <= 1'b0;
            cur_item_q  <= 2'd0;
            timer_q     <= 8'd0;
            wr_ptr_q    <= '{default: '0};
            rd_ptr_q    <= '{default: '0};
            size_q      <= '{default: '0};
            stock_q     <= '{default: INV_INIT};
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            cur_table_q <= cur_table_d;
            cur_item_q  <= cur_item_d;
            timer_q     <= timer_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            size_q      <= size_d;
            stock_q     <= stock_d;
        end
    end

    // NOTE: FIFO storage is not reset; occupancy and pointers alone decide which entries are live.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign table0_order_reject = table0_order_valid && !push[0];
    assign table1_order_reject = table1_order_valid && !push[1];
    assign table0_queue_size   = size_q[0];
    assign table1_queue_size   = size_q[1];
    assign item_ready          = (state_q == DONE);
    assign ready_table         = cur_table_q;
    assign ready_item          = cur_item_q;
    assign kitchen_busy        = (state_q != IDLE);
    assign stock_empty         = {stock_q[3] == 4'd0, stock_q[2] == 4'd0,
                                  stock_q[1] == 4'd0, stock_q[0] == 4'd0};

`ifdef KITCHEN_BILL_EN
    logic [7:0] bill_q [2];
    logic [7:0] bill_d [2];
    logic [7:0] price;
    logic [8:0] bill_sum;

    always_comb begin
        case (cur_item_q)
            2'd0:    price = PRICE0;
            2'd1:    price = PRICE1;
            2'd2:    price = PRICE2;
            default: price = PRICE3;
        endcase
        bill_d   = bill_q;
        bill_sum = {1'b0, bill_q[cur_table_q]} + {1'b0, price};
        if (state_q == DONE)
            bill_d[cur_table_q] = bill_sum[8] ? 8'hFF : bill_sum[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset)
            bill_q <= '{default: '0};
        else
            bill_q <= bill_d;
    end

    assign table0_bill = bill_q[0];
    assign table1_bill = bill_q[1];
`else
    // Prices only feed billing; fold them into a deliberately unused net.
    logic unused_price;
    assign unused_price = ^{PRICE0, PRICE1, PRICE2, PRICE3};
    assign table0_bill  = 8'd0;
    assign table1_bill  = 8'd0;
`endif

endmodule

// File: tb/tb_kitchen_order_scheduler.sv
// Directed bench for kitchen_order_scheduler: per-table scoreboards of expected dishes,
// bill model honouring KITCHEN_BILL_EN, immediate-assertion comparisons.
module tb_kitchen_order_scheduler;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] table0_order_item = 2'd0;
    logic       table0_order_valid = 1'b0;
    logic [1:0] table1_order_item = 2'd0;
    logic       table1_order_valid = 1'b0;
    logic       restock = 1'b0;
    logic       table0_order_reject;
    logic       table1_order_reject;
    logic [2:0] table0_queue_size;
    logic [2:0] table1_queue_size;
    logic       item_ready;
    logic       ready_table;
    logic [1:0] ready_item;
    logic [7:0] table0_bill;
    logic [7:0] table1_bill;
    logic       kitchen_busy;
    logic [3:0] stock_empty;

    int         vectors = 0;
    int         miscompares = 0;
    logic [1:0] sb0 [$];
    logic [1:0] sb1 [$];
    int         exp_bill0 = 0;
    int         exp_bill1 = 0;

    kitchen_order_scheduler dut (
        .clk                (clk),
        .reset              (reset),
        .table0_order_item  (table0_order_item),
        .table0_order_valid (table0_order_valid),
        .table1_order_item  (table1_order_item),
        .table1_order_valid (table1_order_valid),
        .restock            (restock),
        .table0_order_reject(table0_order_reject),
        .table1_order_reject(table1_order_reject),
        .table0_queue_size  (table0_queue_size),
        .table1_queue_size  (table1_queue_size),
        .item_ready         (item_ready),
        .ready_table        (ready_table),
        .ready_item         (ready_item),
        .table0_bill        (table0_bill),
        .table1_bill        (table1_bill),
        .kitchen_busy       (kitchen_busy),
        .stock_empty        (stock_empty)
    );

    always #5 clk = ~clk;

    function automatic int price_of(input logic [1:0] it);
        case (it)
            2'd0:    return 10;
            2'd1:    return 20;
            2'd2:    return 30;
            default: return 40;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic bill_add(input logic t, input logic [1:0] it);
`ifdef KITCHEN_BILL_EN
        if (t == 1'b0) exp_bill0 = (exp_bill0 + price_of(it) > 255) ? 255 : exp_bill0 + price_of(it);
        else           exp_bill1 = (exp_bill1 + price_of(it) > 255) ? 255 : exp_bill1 + price_of(it);
`else
        if (t == 1'b0 && it == 2'd3) exp_bill0 = 0;
`endif
    endtask

    // Advance to just after the next rising edge and score any completed dish.
    task automatic tick();
        logic [1:0] e;
        @(posedge clk);
        #1;
        if (item_ready === 1'b1) begin
            if (ready_table === 1'b0 && sb0.size() > 0) begin
                e = sb0.pop_front();
                check("sb_item_t0", ready_item, e);
                bill_add(1'b0, e);
            end else if (ready_table === 1'b1 && sb1.size() > 0) begin
                e = sb1.pop_front();
                check("sb_item_t1", ready_item, e);
                bill_add(1'b1, e);
            end else begin
                check("spurious_ready", item_ready, 1'b0);
            end
        end
    endtask

    task automatic offer(input logic v0, input logic [1:0] i0, input logic v1, input logic [1:0] i1,
                         input logic rs, input logic er0, input logic er1, input string tag);
        table0_order_valid = v0;
        table0_order_item  = i0;
        table1_order_valid = v1;
        table1_order_item  = i1;
        restock            = rs;
        #1;
        check({tag, "_rej0"}, table0_order_reject, er0);
        check({tag, "_rej1"}, table1_order_reject, er1);
        if (v0 && !er0) sb0.push_back(i0);
        if (v1 && !er1) sb1.push_back(i1);
        tick();
        table0_order_valid = 1'b0;
        table1_order_valid = 1'b0;
        restock            = 1'b0;
    endtask

    task automatic wait_ready(input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (item_ready !== 1'b1 && n < budget);
        check("wait_ready_timeout", item_ready, 1'b1);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((table0_queue_size !== 3'd0 || table1_queue_size !== 3'd0 || kitchen_busy !== 1'b0)
               && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_drain_busy"}, kitchen_busy, 1'b0);
        check({tag, "_drain_q0"}, table0_queue_size, 0);
        check({tag, "_drain_q1"}, table1_queue_size, 0);
        check({tag, "_sb_left"}, sb0.size() + sb1.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;

        // Reset state
        reset = 1'b1;
        tick();
        tick();
        check("rst_ready", item_ready, 1'b0);
        check("rst_busy", kitchen_busy, 1'b0);
        check("rst_stock_empty", stock_empty, 4'b0000);
        check("rst_q0", table0_queue_size, 0);
        check("rst_q1", table1_queue_size, 0);
        check("rst_bill0", table0_bill, 0);
        check("rst_bill1", table1_bill, 0);
        reset = 1'b0;

        // Single item-2 order: head present in IDLE at M, ready at M+6
        offer(1'b1, 2'd2, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, "t1_order");
        check("t1_qsize_m", table0_queue_size, 1);
        check("t1_busy_m", kitchen_busy, 1'b0);
        tick();
        check("t1_qsize_load", table0_queue_size, 0);
        check("t1_busy_load", kitchen_busy, 1'b1);
        wait_ready(20, n);
        check("t1_latency", n + 1, 6);
        check("t1_ready_table", ready_table, 1'b0);
        check("t1_ready_item", ready_item, 2'd2);
        tick();
        check("t1_item_ready_pulse", item_ready, 1'b0);
        check("t1_bill0", table0_bill, exp_bill0);
        check("t1_busy_end", kitchen_busy, 1'b0);

        // Stock exhaustion of item 0, then restock
        for (int k = 0; k < 5; k++)
            offer(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, "t2_accept");
        check("t2_stock_empty", stock_empty, 4'b0001);
        offer(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, "t2_sixth");
        offer(1'b0, 2'd0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b1, "t2_restock");
        check("t2_stock_refilled", stock_empty, 4'b0000);
        offer(1'b1, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, "t2_after_restock");
        drain("t2", 300);
        check("t2_bill0", table0_bill, exp_bill0);

        // Table1 fills while the kitchen is busy, then a pop frees a slot for a same-cycle push
        offer(1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, "t3_seed");
        for (int k = 1; k <= 9; k++) begin
            offer(1'b0, 2'd0, 1'b1, 2'd1, 1'b0, 1'b0, (k >= 5 && k <= 8), "t3_push");
            check("t3_qsize1", table1_queue_size, (k < 4) ? k : 4);
        end
        drain("t3", 300);
        check("t3_bill1", table1_bill, exp_bill1);

        // Two item-1 orders per table: completions alternate 0,1,0,1
        offer(1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, "t4_restock");
        offer(1'b1, 2'd1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, "t4_pair_a");
        offer(1'b1, 2'd1, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, "t4_pair_b");
        for (int j = 0; j < 4; j++) begin
            wait_ready(40, n);
            check("t4_gap", n, (j == 0) ? 4 : 6);
            check("t4_table", ready_table, j % 2);
            check("t4_item", ready_item, 2'd1);
        end
        drain("t4", 100);

        // Contested last unit of item 3 with the pointer at table 1
        for (int k = 0; k < 4; k++)
            offer(1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, "t5_fill");
        drain("t5a", 300);
        offer(1'b1, 2'd3, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0, "t5_tie");
        check("t5_stock_empty", stock_empty, 4'b1000);
        drain("t5b", 100);
        check("t5_bill0", table0_bill, exp_bill0);
        check("t5_bill1", table1_bill, exp_bill1);

        // Reset while item 3 is cooking
        offer(1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, "t6_restock");
        offer(1'b1, 2'd3, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, "t6_orders");
        tick();
        tick();
        check("t6_cooking", kitchen_busy, 1'b1);
        check("t6_q1_pending", table1_queue_size, 1);
        reset = 1'b1;
        tick();
        sb0.delete();
        sb1.delete();
        exp_bill0 = 0;
        exp_bill1 = 0;
        check("t6_rst_ready", item_ready, 1'b0);
        check("t6_rst_busy", kitchen_busy, 1'b0);
        check("t6_rst_q0", table0_queue_size, 0);
        check("t6_rst_q1", table1_queue_size, 0);
        check("t6_rst_bill0", table0_bill, 0);
        check("t6_rst_bill1", table1_bill, 0);
        check("t6_rst_stock_empty", stock_empty, 4'b0000);
        reset = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        check("t6_no_ready", item_ready, 1'b0);
        for (int k = 0; k < 5; k++)
            offer(1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, "t6_refill");
        check("t6_stock3_empty", stock_empty, 4'b1000);
        offer(1'b1, 2'd3, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0, "t6_sixth");
        drain("t6", 300);
        check("t6_bill0", table0_bill, exp_bill0);
        check("t6_bill1", table1_bill, exp_bill1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/kitchen_order_scheduler.md
KITCHEN_ORDER_SCHEDULER -- requirements
Module: kitchen_order_scheduler

Interface
REQ-001 The block SHALL have parameter QDEPTH, default 4, giving the per-table order FIFO depth (power of 2, 2..16).
REQ-002 The block SHALL have parameter INV_INIT, default 5, giving the per-item stock loaded at reset or restock (4-bit).
REQ-003 The block SHALL have parameters PREP0..PREP3, defaults 2/3/4/5, giving the cook cycles per item (8-bit, each ≥1).
REQ-004 The block SHALL have parameters PRICE0..PRICE3, defaults 10/20/30/40, giving the price per item (8-bit).
REQ-005 The block SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-006 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have ports table0_order_item and table1_order_item, input, 2 bits: item code of the offered order.
REQ-008 The block SHALL have ports table0_order_valid and table1_order_valid, input, 1 bit: order offered this cycle.
REQ-009 The block SHALL have port restock, input, 1 bit: reload all four stock counters to INV_INIT.
REQ-010 The block SHALL have ports table0_order_reject and table1_order_reject, output, 1 bit, combinational: valid order refused this cycle.
REQ-011 The block SHALL have ports table0_queue_size and table1_queue_size, output, log2(QDEPTH)+1 bits: FIFO occupancy.
REQ-012 The block SHALL have port item_ready, output, 1 bit: one-cycle pulse when a dish completes.
REQ-013 The block SHALL have ports ready_table (1 bit) and ready_item (2 bits), output: owner and code of the completed dish, valid with item_ready.
REQ-014 The block SHALL have ports table0_bill and table1_bill, output, 8 bits: accumulated charges.
REQ-015 The block SHALL have port kitchen_busy, output, 1 bit: high in every state except IDLE.
REQ-016 The block SHALL have port stock_empty, output, 4 bits: bit i high when stock[i]==0.

Function
REQ-017 Acceptance rule: an order SHALL be accepted iff valid, FIFO not full, stock[item]>0, and restock low; otherwise reject is high in that same cycle when valid is high.
REQ-018 On accept, the item SHALL be pushed into the table FIFO, that FIFO's size SHALL increment, and stock[item] SHALL decrement, all visible in the next cycle.
REQ-019 When both tables request the same item with stock==1, the table selected by the round-robin pointer SHALL be accepted and the other SHALL be rejected.
REQ-020 When both tables request the same item with stock≥2, both SHALL be accepted and stock SHALL drop by 2.
REQ-021 The FSM SHALL have states IDLE, LOAD, COOK and DONE.
REQ-022 IDLE→LOAD SHALL occur when any FIFO is non-empty; the pointed-to table SHALL be chosen if non-empty, otherwise the other table.
REQ-023 Entering LOAD SHALL pop the chosen FIFO's head, latch table and item, and load timer=PREPitem.
REQ-024 LOAD→COOK SHALL occur unconditionally.
REQ-025 COOK SHALL decrement the timer each cycle, last exactly PREPitem cycles, then go to DONE.
REQ-026 DONE SHALL assert item_ready/ready_table/ready_item for exactly one cycle, add the price to the owner's bill, point round-robin to the other table, and go to IDLE.
REQ-027 Latency: if the FIFO head is present in IDLE at cycle M, item_ready SHALL be high at cycle M+PREP+2.
REQ-028 A push and a pop on the same FIFO in the same cycle SHALL leave its size unchanged; a pop from a full FIFO SHALL allow a push in that cycle.
REQ-029 Bills SHALL saturate at 255 and never wrap.
REQ-030 FIFO pointers SHALL wrap modulo QDEPTH.
REQ-031 Restock SHALL not affect FIFOs, the FSM or bills.

Reset
REQ-032 Reset SHALL set the FSM to IDLE, empty both FIFOs, set stock[0..3]=INV_INIT, set bills to 0, point round-robin to table 0, and clear timer.
REQ-033 Under reset, item_ready, kitchen_busy and stock_empty SHALL all be 0 on the cycle after reset is sampled.
REQ-034 Reset asserted mid-COOK SHALL abandon the dish with no item_ready and no billing.
REQ-035 Reset SHALL take priority over all other inputs.

Configuration
REQ-036 When macro KITCHEN_BILL_EN is defined, bills SHALL accumulate per REQ-026 and REQ-029.
REQ-037 When KITCHEN_BILL_EN is undefined, table0_bill and table1_bill SHALL be constant 0 and no bill registers or adders SHALL be built; all other behaviour SHALL be unchanged.

Verification
REQ-038 The bench SHALL cover: after reset, table0 orders item 2 once → queue_size 1 next cycle, item_ready with table 0, item 2 at M+6, table0_bill=30 (KITCHEN_BILL_EN).
REQ-039 The bench SHALL cover: six table0 orders of item 0 at INV_INIT=5 → sixth rejected, stock_empty[0]=1; restock → next item-0 order accepted.
REQ-040 The bench SHALL cover: five back-to-back table1 orders at QDEPTH=4, kitchen idle then busy → fifth accepted only if a pop occurred that cycle, else rejected, queue_size never exceeds 4.
REQ-041 The bench SHALL cover: both tables hold two orders of item 1 → completions alternate 0,1,0,1, each 5 cycles after the previous IDLE.
REQ-042 The bench SHALL cover: both tables order item 3 with stock 1, pointer at table 1 → table1 accepted, table0 rejected.
REQ-043 The bench SHALL cover: reset raised during COOK of item 3 → no item_ready, bills 0, queues 0, stock back to 5.
